// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer game sequencer.
// Includes the state encoding, countdown control codes and delay clamp.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    GO,
    DONE,
    FALSE
  } state_t;

  localparam logic       CD_LOAD  = 1'b0;
  localparam logic       CD_RUN   = 1'b1;
  localparam logic [1:0] EN_COUNT = 2'b01;
  localparam logic [1:0] EN_HOLD  = 2'b00;

  localparam logic [11:0] MIN_DELAY_DEF = 12'd500;
  localparam logic [13:0] MAX_MS_DEF    = 14'd9999;
  localparam int          GUARD_DEF     = 2;

  function automatic logic [11:0] clamp_delay(
    input logic [11:0] r,
    input logic [11:0] floor_v
  );
    return (r < floor_v) ? floor_v : r;
  endfunction

endpackage

// File: rtl/reaction_ctrl_rise_detect.sv
// Registered rising-edge detector with async reset.
// The first cycle after reset is masked so a held level gives no edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic rise
);

  logic prev_q;
  logic prev_d;
  logic arm_q;
  logic arm_d;

  always_comb begin
    prev_d = lvl;
    arm_d  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

  assign rise = lvl & ~prev_q & arm_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer game sequencer on the 1 kHz tick clock.
// Loads the countdown, measures reaction ms, tracks best time.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter logic [11:0] MIN_DELAY = MIN_DELAY_DEF,
  parameter logic [13:0] MAX_MS    = MAX_MS_DEF,
  parameter int          GUARD     = GUARD_DEF
) (
  input  logic        clk1k,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        react_btn,
  input  logic [11:0] rnd,
  input  logic        countdown_finish,
  output logic [11:0] cd_num,
  output logic        cd_start,
  output logic [1:0]  cd_en,
  output logic        led_go,
  output logic [13:0] react_ms,
  output logic [13:0] best_ms,
  output logic        result_valid,
  output logic        false_start,
  output logic        timeout
);

  state_t      state_q, state_d;
  logic [11:0] cd_num_q, cd_num_d;
  logic [13:0] react_q, react_d;
  logic [13:0] best_q, best_d;
  logic        rv_q, rv_d;
  logic        fs_q, fs_d;
  logic        to_q, to_d;
  logic [3:0]  guard_q, guard_d;
  logic [13:0] react_inc;
  logic        start_rise;
  logic        react_rise;

  rise_detect u_start (
    .clk  (clk1k),
    .rst  (rst),
    .lvl  (start_btn),
    .rise (start_rise)
  );

  rise_detect u_react (
    .clk  (clk1k),
    .rst  (rst),
    .lvl  (react_btn),
    .rise (react_rise)
  );

  assign react_inc = react_q + 14'd1;

  always_comb begin
    state_d  = state_q;
    cd_num_d = cd_num_q;
    react_d  = react_q;
    best_d   = best_q;
    rv_d     = rv_q;
    fs_d     = fs_q;
    to_d     = to_q;
    guard_d  = guard_q;
    cd_start = CD_RUN;
    cd_en    = EN_HOLD;
    led_go   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cd_start = CD_LOAD;
        if (start_rise) begin
          cd_num_d = clamp_delay(rnd, MIN_DELAY);
          state_d  = ARM;
        end
      end
      ARM: begin
        cd_start = CD_LOAD;
        guard_d  = 4'(GUARD);
        state_d  = WAIT;
      end
      WAIT: begin
        cd_en = EN_COUNT;
        // a finish left high by the last round is ignored until guard expires
        if (guard_q != 4'd0) guard_d = guard_q - 4'd1;
        if (react_rise) begin
          fs_d    = 1'b1;
          state_d = FALSE;
        end else if (guard_q == 4'd0 && countdown_finish) begin
          react_d = '0;
          state_d = GO;
        end
      end
      GO: begin
        led_go = 1'b1;
        if (react_rise) begin
          rv_d    = 1'b1;
          state_d = DONE;
          if (react_q < best_q) best_d = react_q;
        end else if (react_inc >= MAX_MS) begin
          react_d = MAX_MS;
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          react_d = react_inc;
        end
      end
      DONE: begin
        if (start_rise) begin
          rv_d     = 1'b0;
          to_d     = 1'b0;
          cd_num_d = clamp_delay(rnd, MIN_DELAY);
          state_d  = ARM;
        end
      end
      FALSE: begin
        if (start_rise) begin
          fs_d     = 1'b0;
          cd_num_d = clamp_delay(rnd, MIN_DELAY);
          state_d  = ARM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1k or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cd_num_q <= MIN_DELAY;
      react_q  <= '0;
      best_q   <= MAX_MS;
      rv_q     <= 1'b0;
      fs_q     <= 1'b0;
      to_q     <= 1'b0;
      guard_q  <= '0;
    end else begin
      state_q  <= state_d;
      cd_num_q <= cd_num_d;
      react_q  <= react_d;
      best_q   <= best_d;
      rv_q     <= rv_d;
      fs_q     <= fs_d;
      to_q     <= to_d;
      guard_q  <= guard_d;
    end
  end

  assign cd_num       = cd_num_q;
  assign react_ms     = react_q;
  assign best_ms      = best_q;
  assign result_valid = rv_q;
  assign false_start  = fs_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with hand-computed expectations.
// Countdown behaviour is emulated by driving countdown_finish directly.
module tb_reaction_ctrl;

  logic        clk1k = 1'b0;
  logic        rst = 1'b1;
  logic        start_btn = 1'b0;
  logic        react_btn = 1'b0;
  logic [11:0] rnd = 12'd0;
  logic        countdown_finish = 1'b0;
  logic [11:0] cd_num;
  logic        cd_start;
  logic [1:0]  cd_en;
  logic        led_go;
  logic [13:0] react_ms;
  logic [13:0] best_ms;
  logic        result_valid;
  logic        false_start;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  reaction_ctrl dut (
    .clk1k            (clk1k),
    .rst              (rst),
    .start_btn        (start_btn),
    .react_btn        (react_btn),
    .rnd              (rnd),
    .countdown_finish (countdown_finish),
    .cd_num           (cd_num),
    .cd_start         (cd_start),
    .cd_en            (cd_en),
    .led_go           (led_go),
    .react_ms         (react_ms),
    .best_ms          (best_ms),
    .result_valid     (result_valid),
    .false_start      (false_start),
    .timeout          (timeout)
  );

  always #5 clk1k = ~clk1k;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1k);
    #1;
  endtask

  // start edge -> ARM -> first WAIT cycle
  task automatic start_round(input logic [11:0] r, input logic [11:0] exp_num);
    rnd = r;
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    check("arm_cd_start", cd_start, 0);
    check("arm_cd_num", cd_num, exp_num);
    check("arm_rv_clr", result_valid, 0);
    check("arm_to_clr", timeout, 0);
    check("arm_fs_clr", false_start, 0);
    tick();
    check("wait_cd_start", cd_start, 1);
    check("wait_cd_en", cd_en, 1);
    check("wait_led", led_go, 0);
  endtask

  task automatic round(input logic [11:0] r, input logic [11:0] exp_num,
                       input int wait_n, input int react_n,
                       input logic [13:0] exp_best);
    start_round(r, exp_num);
    repeat (wait_n - 1) tick();
    check("pre_go_led", led_go, 0);
    countdown_finish = 1'b1;
    tick();
    countdown_finish = 1'b0;
    check("go_led", led_go, 1);
    check("go_cd_en", cd_en, 0);
    check("go_react_clr", react_ms, 0);
    repeat (react_n) tick();
    check("go_count", react_ms, react_n);
    react_btn = 1'b1;
    tick();
    react_btn = 1'b0;
    check("done_react", react_ms, react_n);
    check("done_rv", result_valid, 1);
    check("done_led", led_go, 0);
    check("done_best", best_ms, exp_best);
  endtask

  initial begin
    // reset values, start held high through reset
    rnd = 12'd800;
    start_btn = 1'b1;
    tick();
    check("rst_led", led_go, 0);
    check("rst_cd_start", cd_start, 0);
    check("rst_cd_en", cd_en, 0);
    check("rst_cd_num", cd_num, 500);
    check("rst_react", react_ms, 0);
    check("rst_best", best_ms, 9999);
    check("rst_rv", result_valid, 0);
    check("rst_fs", false_start, 0);
    check("rst_to", timeout, 0);
    rst = 1'b0;
    tick();
    tick();
    check("held_no_edge_en", cd_en, 0);
    check("held_no_edge_num", cd_num, 500);
    start_btn = 1'b0;
    tick();

    // normal round
    round(12'd800, 12'd800, 800, 237, 14'd237);
    // minimum delay floor
    round(12'd3, 12'd500, 500, 500, 14'd237);

    // false start 100 cycles into WAIT
    start_round(12'd900, 12'd900);
    repeat (99) tick();
    react_btn = 1'b1;
    tick();
    react_btn = 1'b0;
    check("fs_flag", false_start, 1);
    check("fs_led", led_go, 0);
    check("fs_cd_en", cd_en, 0);
    check("fs_react_held", react_ms, 500);
    check("fs_best", best_ms, 237);
    repeat (3) tick();
    check("fs_led_hold", led_go, 0);
    check("fs_flag_hold", false_start, 1);
    start_round(12'd1200, 12'd1200);

    // round ending with finish left high
    repeat (48) tick();
    countdown_finish = 1'b1;
    tick();
    check("r4_go", led_go, 1);
    repeat (400) tick();
    react_btn = 1'b1;
    tick();
    react_btn = 1'b0;
    check("r4_react", react_ms, 400);
    check("r4_best", best_ms, 237);

    // stale finish across the guard window
    start_round(12'd1000, 12'd1000);
    tick();
    check("stale_g1", led_go, 0);
    tick();
    check("stale_g2", led_go, 0);
    countdown_finish = 1'b0;
    repeat (5) tick();
    check("stale_low", led_go, 0);
    countdown_finish = 1'b1;
    tick();
    countdown_finish = 1'b0;
    check("fresh_go", led_go, 1);

    // timeout
    repeat (9998) tick();
    check("to_pre_react", react_ms, 9998);
    check("to_pre_led", led_go, 1);
    check("to_pre_flag", timeout, 0);
    tick();
    check("to_react", react_ms, 9999);
    check("to_flag", timeout, 1);
    check("to_led", led_go, 0);
    check("to_best", best_ms, 237);
    repeat (5) tick();
    check("to_sat", react_ms, 9999);
    check("to_hold", timeout, 1);

    // simultaneous edges: start wins in DONE, react wins in WAIT
    rnd = 12'd700;
    start_btn = 1'b1;
    react_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    react_btn = 1'b0;
    check("sim_done_arm", cd_start, 0);
    check("sim_done_num", cd_num, 700);
    check("sim_done_to", timeout, 0);
    tick();
    check("sim_wait_en", cd_en, 1);
    repeat (5) tick();
    start_btn = 1'b1;
    react_btn = 1'b1;
    countdown_finish = 1'b1;
    tick();
    start_btn = 1'b0;
    react_btn = 1'b0;
    countdown_finish = 1'b0;
    check("sim_wait_fs", false_start, 1);
    check("sim_wait_led", led_go, 0);

    // reset, then best tracking
    #2 rst = 1'b1;
    #1;
    check("rst2_best", best_ms, 9999);
    check("rst2_fs", false_start, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    round(12'd600, 12'd600, 10, 300, 14'd300);
    round(12'd600, 12'd600, 10, 250, 14'd250);
    round(12'd600, 12'd600, 10, 410, 14'd250);

    // async reset mid-GO
    start_round(12'd600, 12'd600);
    repeat (9) tick();
    countdown_finish = 1'b1;
    tick();
    countdown_finish = 1'b0;
    check("mid_go_led", led_go, 1);
    repeat (20) tick();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_led", led_go, 0);
    check("mid_rst_best", best_ms, 9999);
    check("mid_rst_cd_en", cd_en, 0);
    check("mid_rst_cd_start", cd_start, 0);
    check("mid_rst_react", react_ms, 0);
    check("mid_rst_rv", result_valid, 0);
    check("mid_rst_num", cd_num, 500);
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reaction_ctrl.md
Name: reaction_ctrl

Overview:
- Top-level game sequencer for the reaction timer. Runs on the 1 kHz tick clock, so one cycle is 1 ms.
- Captures a random delay from the LFSR and drives the countdown block's load/enable interface.
- When the countdown finishes, lights the GO indicator and measures reaction time in ms.
- Flags false starts and timeouts, and keeps a best-time register for the display logic.

Parameters:
- MIN_DELAY, 12'd500: floor applied to the random delay in ms; guarantees at least 0.5 s of wait.
- MAX_MS, 14'd9999: saturation and timeout value of the reaction counter; fits a 4-digit display.
- GUARD, 2: number of WAIT cycles during which countdown_finish is ignored.

Ports:
- clk1k, input, 1: 1 kHz system clock.
- rst, input, 1: asynchronous, active-high reset.
- start_btn, input, 1: debounced, synchronized level. The rising edge starts a round.
- react_btn, input, 1: debounced, synchronized level. The rising edge is the player response.
- rnd, input, 12: free-running LFSR value.
- countdown_finish, input, 1: from the countdown block.
- cd_num, output, 12: delay value presented to the countdown num input.
- cd_start, output, 1: countdown start. 0 = load, 1 = run.
- cd_en, output, 2: countdown enable. 2'b01 = count, 2'b00 = hold.
- led_go, output, 1: stimulus indicator.
- react_ms, output, 14: last reaction time in ms.
- best_ms, output, 14: best valid reaction time since reset.
- result_valid, output, 1: high while react_ms holds a completed result.
- false_start, output, 1: high while in the FALSE state.
- timeout, output, 1: high while in DONE after a timeout.

Behaviour:
- Reset (asynchronous, rst=1):
  - State = IDLE, cd_start = 0, cd_en = 2'b00, cd_num = MIN_DELAY.
  - led_go = 0, react_ms = 0, best_ms = MAX_MS.
  - result_valid = 0, false_start = 0, timeout = 0.
  - Edge-detect history registers are cleared.
- Edge detection: rising edge = level is 1 this cycle and was 0 the previous cycle.
  - A button held through reset produces no edge.
- IDLE: cd_start = 0, cd_en = 00.
  - On start edge: cd_num <= (rnd < MIN_DELAY) ? MIN_DELAY : rnd, then go to ARM.
- ARM (1 cycle): cd_start = 0 so the countdown loads cd_num. Go to WAIT.
- WAIT:
  - Outputs: cd_start = 1, cd_en = 01. A guard counter runs for GUARD cycles.
  - countdown_finish is ignored while the guard counter is running, because a stale 1 from the previous round can be present.
  - React edge → FALSE. This takes priority over countdown_finish in the same cycle.
  - countdown_finish = 1 after the guard → GO. react_ms is cleared on the same edge.
- GO:
  - Outputs: led_go = 1, cd_en = 00, and react_ms increments by 1 each cycle.
  - React edge → DONE.
    - On that edge react_ms holds the count; the press cycle itself is not counted.
    - result_valid <= 1.
    - If react_ms < best_ms, best_ms <= react_ms.
  - react_ms reaches MAX_MS → DONE with timeout = 1.
    - react_ms saturates at MAX_MS and best_ms is not updated.
  - Start edges are ignored in GO.
- DONE:
  - led_go = 0. react_ms, result_valid and timeout are held.
  - Start edge → clear result_valid and timeout, capture cd_num, go to ARM.
- FALSE:
  - false_start = 1, led_go = 0, cd_en = 00, and react_ms is unchanged.
  - Start edge → clear false_start, capture cd_num, go to ARM.
- Simultaneous start and react edges:
  - In IDLE, DONE and FALSE, start wins.
  - In WAIT and GO, react wins.
- React edges in IDLE, ARM, DONE and FALSE are ignored.
- Reset mid-round returns to IDLE immediately and drops led_go asynchronously.
- Arithmetic: all counters are unsigned. react_ms never wraps. best_ms compare is unsigned less-than.

Decomposition:
- Package reaction_pkg contains:
  - The state enum: IDLE, ARM, WAIT, GO, DONE, FALSE.
  - CD_LOAD = 1'b0, CD_RUN = 1'b1, EN_COUNT = 2'b01, EN_HOLD = 2'b00.
  - The default MAX_MS and MIN_DELAY values.
- One sub-module, rise_detect: a 1-bit registered edge detector with async reset, instantiated twice (start and react).

Test Plan:
1. Normal round: rst pulse; rnd = 12'd800; start edge; countdown model finishes after 800 cycles.
   - Required: cd_start = 0 for exactly 1 cycle (ARM) with cd_num = 800, then 1; led_go rises.
   - React edge 237 cycles after led_go → react_ms = 237, result_valid = 1, best_ms = 237.
2. Minimum delay: rnd = 12'd3 at the start edge.
   - Required: cd_num = 500, and no GO before the countdown model asserts finish.
3. False start: press react 100 cycles into WAIT.
   - Required: false_start = 1, led_go never 1, best_ms unchanged.
   - Next start edge clears false_start and re-enters ARM.
4. Stale finish: leave countdown_finish = 1 from the prior round, then start a new round.
   - Required: the controller stays in WAIT through the guard window and reaches GO only on a fresh assertion.
5. Timeout: no react press in GO.
   - Required: after 9999 cycles, react_ms = 9999, timeout = 1, best_ms unchanged.
   - Extra cycles keep react_ms at 9999.
6. Best tracking and reset: run rounds with results 300, 250, 410.
   - Required: best_ms = 300, then 250, then 250.
   - Assert rst mid-GO → led_go = 0 immediately, state IDLE, best_ms = 9999.
